// File: rtl/minute_second_counter.sv
// Minute/second counter: prescaled seconds tick, mm:ss BCD digits, button-adjusted minutes.
// Optional macro ADJ_CARRY_EN: min_add wrapping 59->0 also pulses min_carry.
module minute_second_counter #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       min_add,
  input  logic       min_reduce,
  input  logic       sec_clear,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       min_carry,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

`ifdef ADJ_CARRY_EN
  localparam logic ADJ_CARRY = 1'b1;
`else
  localparam logic ADJ_CARRY = 1'b0;
`endif

  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic          r_add_q;
  logic          r_red_q;
  logic          r_clr_q;
  logic          r_min_carry;
  logic          r_sec_tick;

  logic          w_add_e;
  logic          w_red_e;
  logic          w_clr_e;
  logic          w_tick;
  logic          w_carry_ev;
  logic          w_min_wrap;
  logic [PW-1:0] w_presc_nxt;
  logic [5:0]    w_sec_nxt;
  logic [5:0]    w_min_nxt;
  logic          w_carry_nxt;
  logic          w_tick_nxt;

  assign w_add_e    = min_add & ~r_add_q;
  assign w_red_e    = min_reduce & ~r_red_q;
  assign w_clr_e    = sec_clear & ~r_clr_q;
  assign w_tick     = (r_presc == LAST);
  assign w_min_wrap = (r_min == 6'd59);

  // Prescaler and seconds: clear beats the tick, tick advances seconds.
  always_comb begin
    w_presc_nxt = r_presc + PW'(1);
    w_sec_nxt   = r_sec;
    w_carry_ev  = 1'b0;
    w_tick_nxt  = 1'b0;
    if (w_clr_e) begin
      w_presc_nxt = '0;
      w_sec_nxt   = '0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      w_tick_nxt  = 1'b1;
      if (r_sec == 6'd59) begin
        w_sec_nxt  = '0;
        w_carry_ev = 1'b1;
      end else begin
        w_sec_nxt = r_sec + 6'd1;
      end
    end
  end

  // Minutes: carry > add > reduce; losers in the same cycle are dropped.
  always_comb begin
    w_min_nxt   = r_min;
    w_carry_nxt = 1'b0;
    if (w_carry_ev) begin
      w_min_nxt   = w_min_wrap ? 6'd0 : r_min + 6'd1;
      w_carry_nxt = w_min_wrap;
    end else if (w_add_e) begin
      w_min_nxt   = w_min_wrap ? 6'd0 : r_min + 6'd1;
      w_carry_nxt = w_min_wrap & ADJ_CARRY;
    end else if (w_red_e) begin
      w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
    end
  end

  // State registers, edge-detect samples and registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc     <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_add_q     <= 1'b0;
      r_red_q     <= 1'b0;
      r_clr_q     <= 1'b0;
      r_min_carry <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_sec       <= w_sec_nxt;
      r_min       <= w_min_nxt;
      r_add_q     <= min_add;
      r_red_q     <= min_reduce;
      r_clr_q     <= sec_clear;
      r_min_carry <= w_carry_nxt;
      r_sec_tick  <= w_tick_nxt;
    end
  end

  assign sec_tens  = 4'(r_sec / 6'd10);
  assign sec_ones  = 4'(r_sec % 6'd10);
  assign min_tens  = 4'(r_min / 6'd10);
  assign min_ones  = 4'(r_min % 6'd10);
  assign min_carry = r_min_carry;
  assign sec_tick  = r_sec_tick;

endmodule
